// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the D-cache, I-cache, memory port and mem_bus_arbiter.
// The arbiter takes the slave side; the cache/memory environment takes master.
interface mem_bus_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [1:0]       dc2arb_command;
    logic [XLEN-1:0]  dc2arb_addr;
    logic [63:0]      dc2arb_data;
    logic [1:0]       ic2arb_command;
    logic [XLEN-1:0]  ic2arb_addr;
    logic [1:0]       arb2mem_command;
    logic [XLEN-1:0]  arb2mem_addr;
    logic [63:0]      arb2mem_data;
    logic [TAG_W-1:0] mem2arb_response;
    logic [63:0]      mem2arb_data;
    logic [TAG_W-1:0] mem2arb_tag;
    logic             arb2dc_accept;
    logic             arb2dc_valid;
    logic [63:0]      arb2dc_data;
    logic             arb2ic_accept;
    logic             arb2ic_valid;
    logic [63:0]      arb2ic_data;

    modport slave (
        input  dc2arb_command, dc2arb_addr, dc2arb_data,
        input  ic2arb_command, ic2arb_addr,
        input  mem2arb_response, mem2arb_data, mem2arb_tag,
        output arb2mem_command, arb2mem_addr, arb2mem_data,
        output arb2dc_accept, arb2dc_valid, arb2dc_data,
        output arb2ic_accept, arb2ic_valid, arb2ic_data
    );

    modport master (
        output dc2arb_command, dc2arb_addr, dc2arb_data,
        output ic2arb_command, ic2arb_addr,
        output mem2arb_response, mem2arb_data, mem2arb_tag,
        input  arb2mem_command, arb2mem_addr, arb2mem_data,
        input  arb2dc_accept, arb2dc_valid, arb2dc_data,
        input  arb2ic_accept, arb2ic_valid, arb2ic_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the tagged memory port between D-cache and I-cache, tracks tag owners
// and routes load returns. Define ARB_STATS_EN to add grant/stall counters.
module mem_bus_arbiter #(
    parameter int NUM_TAGS     = 16,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ARB_STATS_EN
    output logic [31:0]       stat_dc_grants,
    output logic [31:0]       stat_ic_grants,
    output logic [31:0]       stat_stall_cycles,
`endif
    mem_bus_arbiter_if.slave  bus
);
    localparam logic [1:0]     BUS_NONE = 2'd0;
    localparam logic [1:0]     BUS_LOAD = 2'd1;
    localparam logic [TAG_W:0] LIMIT    = STARVE_LIMIT[TAG_W:0];

    logic [NUM_TAGS-1:0] vld_q, vld_d;
    logic [NUM_TAGS-1:0] own_q, own_d;   // 1 = I-cache owns the tag
    logic [TAG_W:0]      starve_q, starve_d;

    logic dc_req, ic_req, gnt_dc, gnt_ic, resp_ok, alloc, ret_hit;

    assign dc_req  = bus.dc2arb_command != BUS_NONE;
    assign ic_req  = bus.ic2arb_command != BUS_NONE;
    assign resp_ok = bus.mem2arb_response != '0;

    always_comb begin
        gnt_dc               = 1'b0;
        gnt_ic               = 1'b0;
        bus.arb2mem_command  = BUS_NONE;
        bus.arb2mem_addr     = '0;
        bus.arb2mem_data     = '0;
        if (!rst) begin
            if (dc_req && starve_q < LIMIT) begin
                gnt_dc              = 1'b1;
                bus.arb2mem_command = bus.dc2arb_command;
                bus.arb2mem_addr    = bus.dc2arb_addr;
                bus.arb2mem_data    = bus.dc2arb_data;
            end else if (ic_req) begin
                gnt_ic              = 1'b1;
                bus.arb2mem_command = bus.ic2arb_command;
                bus.arb2mem_addr    = bus.ic2arb_addr;
            end
        end
    end

    assign bus.arb2dc_accept = gnt_dc && resp_ok;
    assign bus.arb2ic_accept = gnt_ic && resp_ok;
    assign alloc = (bus.arb2dc_accept || bus.arb2ic_accept) && bus.arb2mem_command == BUS_LOAD;

    assign ret_hit          = !rst && bus.mem2arb_tag != '0 && vld_q[bus.mem2arb_tag];
    assign bus.arb2dc_valid = ret_hit && !own_q[bus.mem2arb_tag];
    assign bus.arb2ic_valid = ret_hit &&  own_q[bus.mem2arb_tag];
    assign bus.arb2dc_data  = bus.arb2dc_valid ? bus.mem2arb_data : '0;
    assign bus.arb2ic_data  = bus.arb2ic_valid ? bus.mem2arb_data : '0;

    // Clear-on-return is applied first so a same-cycle reallocation of the tag wins.
    always_comb begin
        vld_d = vld_q;
        own_d = own_q;
        if (ret_hit) vld_d[bus.mem2arb_tag] = 1'b0;
        if (alloc) begin
            vld_d[bus.mem2arb_response] = 1'b1;
            own_d[bus.mem2arb_response] = gnt_ic;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!ic_req || bus.arb2ic_accept) starve_d = '0;
        else if (starve_q < LIMIT)        starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            own_q    <= '0;
            starve_q <= '0;
        end else begin
            vld_q    <= vld_d;
            own_q    <= own_d;
            starve_q <= starve_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] dc_grants_q, ic_grants_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_grants_q <= '0;
            ic_grants_q <= '0;
            stall_q     <= '0;
        end else begin
            if (bus.arb2dc_accept)         dc_grants_q <= dc_grants_q + 32'd1;
            if (bus.arb2ic_accept)         ic_grants_q <= ic_grants_q + 32'd1;
            if ((dc_req || ic_req) && !resp_ok) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_dc_grants    = dc_grants_q;
    assign stat_ic_grants    = ic_grants_q;
    assign stat_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a random run
// compared against a tag-ownership / denial-count reference model.
module tb_mem_bus_arbiter;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.XLEN(32), .TAG_W(4)) bus();

`ifdef ARB_STATS_EN
    logic [31:0] st_dc, st_ic, st_stall;
`endif

    mem_bus_arbiter #(.NUM_TAGS(16), .TAG_W(4), .STARVE_LIMIT(8)) dut (
        .clk(clk),
        .rst(rst),
`ifdef ARB_STATS_EN
        .stat_dc_grants(st_dc),
        .stat_ic_grants(st_ic),
        .stat_stall_cycles(st_stall),
`endif
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    bit m_valid [16];
    bit m_owner [16];
    int m_denied = 0;

    logic [1:0]  exp_mem_cmd = NONE;
    logic [31:0] exp_mem_addr = '0;
    logic [63:0] exp_mem_data = '0;
    logic        exp_dc_acc = 0, exp_ic_acc = 0, exp_dc_vld = 0, exp_ic_vld = 0;
    logic [63:0] exp_dc_data = '0, exp_ic_data = '0;

    task automatic model_comb();
        int t;
        exp_mem_cmd = NONE; exp_mem_addr = '0; exp_mem_data = '0;
        exp_dc_acc = 0; exp_ic_acc = 0; exp_dc_vld = 0; exp_ic_vld = 0;
        exp_dc_data = '0; exp_ic_data = '0;
        if (rst) return;
        if (bus.dc2arb_command != NONE && m_denied < 8) begin
            exp_mem_cmd = bus.dc2arb_command; exp_mem_addr = bus.dc2arb_addr;
            exp_mem_data = bus.dc2arb_data; exp_dc_acc = bus.mem2arb_response != 0;
        end else if (bus.ic2arb_command != NONE) begin
            exp_mem_cmd = bus.ic2arb_command; exp_mem_addr = bus.ic2arb_addr;
            exp_ic_acc = bus.mem2arb_response != 0;
        end
        t = int'(bus.mem2arb_tag);
        if (t != 0 && m_valid[t]) begin
            if (m_owner[t]) begin exp_ic_vld = 1; exp_ic_data = bus.mem2arb_data; end
            else            begin exp_dc_vld = 1; exp_dc_data = bus.mem2arb_data; end
        end
    endtask

    task automatic model_seq();
        int t, r;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_owner[i] = 0; end
            m_denied = 0;
            return;
        end
        t = int'(bus.mem2arb_tag);
        r = int'(bus.mem2arb_response);
        if (t != 0 && m_valid[t]) m_valid[t] = 0;
        if ((exp_dc_acc || exp_ic_acc) && exp_mem_cmd == LOAD) begin
            m_valid[r] = 1; m_owner[r] = exp_ic_acc;
        end
        if (bus.ic2arb_command == NONE || exp_ic_acc) m_denied = 0;
        else if (m_denied < 8) m_denied++;
    endtask

    // Commits the previous cycle into the model, then applies new inputs at negedge.
    task automatic drive(input logic r, input logic [1:0] dcc, input logic [31:0] dca,
                         input logic [63:0] dcd, input logic [1:0] icc, input logic [31:0] ica,
                         input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
        model_seq();
        @(negedge clk);
        rst = r;
        bus.dc2arb_command = dcc; bus.dc2arb_addr = dca; bus.dc2arb_data = dcd;
        bus.ic2arb_command = icc; bus.ic2arb_addr = ica;
        bus.mem2arb_response = resp; bus.mem2arb_tag = rtag; bus.mem2arb_data = rdata;
        #1 model_comb();
    endtask

    task automatic idle(input logic [3:0] rtag, input logic [63:0] rdata);
        drive(0, NONE, 0, 0, NONE, 0, 0, rtag, rdata);
    endtask

    task automatic test_reset();
        drive(1, LOAD, 32'h40, 64'h1, LOAD, 32'h80, 4'd9, 4'd9, 64'hFF);
        drive(1, LOAD, 32'h40, 64'h1, LOAD, 32'h80, 4'd9, 4'd9, 64'hFF);
        n_chk++; if (bus.arb2mem_command !== NONE) begin n_fail++; $display("FAIL reset_cmd got=%0d exp=0", bus.arb2mem_command); end
        n_chk++; if (bus.arb2mem_addr !== 32'h0 || bus.arb2mem_data !== 64'h0) begin n_fail++; $display("FAIL reset_addr_data got=%h/%h exp=0", bus.arb2mem_addr, bus.arb2mem_data); end
        n_chk++; if ({bus.arb2dc_accept, bus.arb2ic_accept, bus.arb2dc_valid, bus.arb2ic_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b%b%b exp=0000", bus.arb2dc_accept, bus.arb2ic_accept, bus.arb2dc_valid, bus.arb2ic_valid); end
        n_chk++; if (bus.arb2dc_data !== 64'h0 || bus.arb2ic_data !== 64'h0) begin n_fail++; $display("FAIL reset_ret_data got=%h/%h exp=0", bus.arb2dc_data, bus.arb2ic_data); end
        idle(0, 0);
    endtask

    task automatic test_dc_load();
        drive(0, LOAD, 32'h100, 64'h0, NONE, 0, 4'd3, 0, 0);
        n_chk++; if (bus.arb2dc_accept !== 1'b1 || bus.arb2ic_accept !== 1'b0) begin n_fail++; $display("FAIL dc_load_accept got dc=%b ic=%b exp dc=1 ic=0", bus.arb2dc_accept, bus.arb2ic_accept); end
        n_chk++; if (bus.arb2mem_command !== LOAD || bus.arb2mem_addr !== 32'h100) begin n_fail++; $display("FAIL dc_load_fwd got cmd=%0d addr=%h exp cmd=1 addr=100", bus.arb2mem_command, bus.arb2mem_addr); end
        idle(0, 0);
        idle(0, 0);
        idle(4'd3, 64'hDEADBEEF_CAFEF00D);
        n_chk++; if (bus.arb2dc_valid !== 1'b1 || bus.arb2dc_data !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL dc_load_return got v=%b d=%h exp v=1 d=deadbeefcafef00d", bus.arb2dc_valid, bus.arb2dc_data); end
        n_chk++; if (bus.arb2ic_valid !== 1'b0) begin n_fail++; $display("FAIL dc_load_ic_quiet got=%b exp=0", bus.arb2ic_valid); end
        idle(0, 0);
        n_chk++; if (bus.arb2dc_valid !== 1'b0 || bus.arb2dc_data !== 64'h0) begin n_fail++; $display("FAIL dc_load_pulse got v=%b d=%h exp v=0 d=0", bus.arb2dc_valid, bus.arb2dc_data); end
        idle(4'd3, 64'h1111);
        n_chk++; if (bus.arb2dc_valid !== 1'b0) begin n_fail++; $display("FAIL dc_load_entry_cleared got=%b exp=0", bus.arb2dc_valid); end
    endtask

    task automatic test_starvation();
        for (int k = 1; k <= 10; k++) begin
            drive(0, LOAD, 32'h300 + k, 64'h0, LOAD, 32'h400, 4'd5, 0, 0);
            n_chk++;
            if (k == 9) begin
                if ({bus.arb2dc_accept, bus.arb2ic_accept} !== 2'b01 || bus.arb2mem_addr !== 32'h400) begin
                    n_fail++; $display("FAIL starve_forced cycle=%0d got dc=%b ic=%b addr=%h exp dc=0 ic=1 addr=400", k, bus.arb2dc_accept, bus.arb2ic_accept, bus.arb2mem_addr);
                end
            end else if ({bus.arb2dc_accept, bus.arb2ic_accept} !== 2'b10) begin
                n_fail++; $display("FAIL starve_dc_wins cycle=%0d got dc=%b ic=%b exp dc=1 ic=0", k, bus.arb2dc_accept, bus.arb2ic_accept);
            end
        end
        idle(4'd5, 64'h5555);
        n_chk++; if (bus.arb2dc_valid !== 1'b1 || bus.arb2ic_valid !== 1'b0) begin n_fail++; $display("FAIL starve_tag5_owner got dc=%b ic=%b exp dc=1 ic=0", bus.arb2dc_valid, bus.arb2ic_valid); end
    endtask

    task automatic test_no_response();
        drive(0, NONE, 0, 0, LOAD, 32'h500, 4'd0, 0, 0);
        n_chk++; if (bus.arb2ic_accept !== 1'b0 || bus.arb2mem_command !== LOAD) begin n_fail++; $display("FAIL noresp_reject got acc=%b cmd=%0d exp acc=0 cmd=1", bus.arb2ic_accept, bus.arb2mem_command); end
        drive(0, NONE, 0, 0, LOAD, 32'h500, 4'd7, 0, 0);
        n_chk++; if (bus.arb2ic_accept !== 1'b1) begin n_fail++; $display("FAIL noresp_retry got=%b exp=1", bus.arb2ic_accept); end
        idle(4'd7, 64'h77);
        n_chk++; if (bus.arb2ic_valid !== 1'b1 || bus.arb2ic_data !== 64'h77 || bus.arb2dc_valid !== 1'b0) begin n_fail++; $display("FAIL noresp_return got icv=%b d=%h dcv=%b exp icv=1 d=77 dcv=0", bus.arb2ic_valid, bus.arb2ic_data, bus.arb2dc_valid); end
    endtask

    task automatic test_store();
        drive(0, STORE, 32'h200, 64'h1234, NONE, 0, 4'd2, 0, 0);
        n_chk++; if (bus.arb2dc_accept !== 1'b1 || bus.arb2mem_command !== STORE || bus.arb2mem_data !== 64'h1234) begin n_fail++; $display("FAIL store_fwd got acc=%b cmd=%0d data=%h exp acc=1 cmd=2 data=1234", bus.arb2dc_accept, bus.arb2mem_command, bus.arb2mem_data); end
        idle(4'd2, 64'h55);
        n_chk++; if (bus.arb2dc_valid !== 1'b0 || bus.arb2ic_valid !== 1'b0) begin n_fail++; $display("FAIL store_no_alloc got dc=%b ic=%b exp 0 0", bus.arb2dc_valid, bus.arb2ic_valid); end
    endtask

    task automatic test_collision();
        drive(0, NONE, 0, 0, LOAD, 32'h700, 4'd4, 0, 0);
        drive(0, LOAD, 32'h710, 0, NONE, 0, 4'd4, 4'd4, 64'hA0A0);
        n_chk++; if (bus.arb2ic_valid !== 1'b1 || bus.arb2ic_data !== 64'hA0A0 || bus.arb2dc_valid !== 1'b0) begin n_fail++; $display("FAIL collide_old_owner got icv=%b d=%h dcv=%b exp icv=1 d=a0a0 dcv=0", bus.arb2ic_valid, bus.arb2ic_data, bus.arb2dc_valid); end
        n_chk++; if (bus.arb2dc_accept !== 1'b1) begin n_fail++; $display("FAIL collide_accept got=%b exp=1", bus.arb2dc_accept); end
        idle(4'd4, 64'hB0B0);
        n_chk++; if (bus.arb2dc_valid !== 1'b1 || bus.arb2dc_data !== 64'hB0B0 || bus.arb2ic_valid !== 1'b0) begin n_fail++; $display("FAIL collide_new_owner got dcv=%b d=%h icv=%b exp dcv=1 d=b0b0 icv=0", bus.arb2dc_valid, bus.arb2dc_data, bus.arb2ic_valid); end
    endtask

    task automatic test_reset_drop();
        drive(0, NONE, 0, 0, LOAD, 32'h600, 4'd6, 0, 0);
        n_chk++; if (bus.arb2ic_accept !== 1'b1) begin n_fail++; $display("FAIL rdrop_accept got=%b exp=1", bus.arb2ic_accept); end
        drive(1, LOAD, 32'h10, 64'h99, LOAD, 32'h600, 4'd6, 4'd6, 64'hAB);
        n_chk++; if (bus.arb2mem_command !== NONE || {bus.arb2dc_accept, bus.arb2ic_accept, bus.arb2dc_valid, bus.arb2ic_valid} !== 4'b0) begin n_fail++; $display("FAIL rdrop_in_reset got cmd=%0d flags=%b%b%b%b exp cmd=0 flags=0000", bus.arb2mem_command, bus.arb2dc_accept, bus.arb2ic_accept, bus.arb2dc_valid, bus.arb2ic_valid); end
        idle(4'd6, 64'hAB);
        n_chk++; if (bus.arb2ic_valid !== 1'b0 || bus.arb2dc_valid !== 1'b0) begin n_fail++; $display("FAIL rdrop_stale_tag got ic=%b dc=%b exp 0 0", bus.arb2ic_valid, bus.arb2dc_valid); end
    endtask

    task automatic test_random();
        logic [1:0] dcc, icc;
        logic [3:0] resp, rtag;
        for (int n = 0; n < 500; n++) begin
            dcc  = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 2) == 0) ? STORE : LOAD) : NONE;
            icc  = ($urandom_range(0, 9) < 6) ? LOAD : NONE;
            resp = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
            rtag = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 99) == 0), dcc, $urandom, {$urandom, $urandom}, icc, $urandom,
                  resp, rtag, {$urandom, $urandom});
            n_chk++; if (bus.arb2mem_command !== exp_mem_cmd) begin n_fail++; $display("FAIL rnd_cmd n=%0d got=%0d exp=%0d", n, bus.arb2mem_command, exp_mem_cmd); end
            n_chk++; if (bus.arb2mem_addr !== exp_mem_addr) begin n_fail++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.arb2mem_addr, exp_mem_addr); end
            n_chk++; if (bus.arb2mem_data !== exp_mem_data) begin n_fail++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, bus.arb2mem_data, exp_mem_data); end
            n_chk++; if (bus.arb2dc_accept !== exp_dc_acc || bus.arb2ic_accept !== exp_ic_acc) begin n_fail++; $display("FAIL rnd_accept n=%0d got dc=%b ic=%b exp dc=%b ic=%b", n, bus.arb2dc_accept, bus.arb2ic_accept, exp_dc_acc, exp_ic_acc); end
            n_chk++; if (bus.arb2dc_valid !== exp_dc_vld || bus.arb2dc_data !== exp_dc_data) begin n_fail++; $display("FAIL rnd_dc_ret n=%0d got v=%b d=%h exp v=%b d=%h", n, bus.arb2dc_valid, bus.arb2dc_data, exp_dc_vld, exp_dc_data); end
            n_chk++; if (bus.arb2ic_valid !== exp_ic_vld || bus.arb2ic_data !== exp_ic_data) begin n_fail++; $display("FAIL rnd_ic_ret n=%0d got v=%b d=%h exp v=%b d=%h", n, bus.arb2ic_valid, bus.arb2ic_data, exp_ic_vld, exp_ic_data); end
        end
    endtask

    initial begin
        bus.dc2arb_command = NONE; bus.dc2arb_addr = '0; bus.dc2arb_data = '0;
        bus.ic2arb_command = NONE; bus.ic2arb_addr = '0;
        bus.mem2arb_response = '0; bus.mem2arb_tag = '0; bus.mem2arb_data = '0;
        test_reset();
        test_dc_load();
        test_starvation();
        test_no_response();
        test_store();
        test_collision();
        test_reset_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single tagged memory port between the D-cache (loads and stores) and the I-cache (loads only).
- Each cycle, picks at most one requester and forwards its command, address and data to memory.
- Records which requester owns each returned transaction tag.
- Routes returning load data back to the owning cache as a one-cycle valid pulse.
- Sits between both caches and the system memory bus, below the LS unit and fetch stage.

Parameters:
- NUM_TAGS, 16: tag space of the memory model; tag 0 means "no transaction".
- TAG_W, 4: width of the tag and response fields; equals log2(NUM_TAGS).
- STARVE_LIMIT, 8: consecutive denied I-cache request cycles before the I-cache is forced to win.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- dc2arb_command, in, 2: BUS_COMMAND from the D-cache (BUS_NONE / BUS_LOAD / BUS_STORE).
- dc2arb_addr, in, XLEN: D-cache address.
- dc2arb_data, in, 64: D-cache store data.
- ic2arb_command, in, 2: BUS_COMMAND from the I-cache (BUS_NONE / BUS_LOAD only).
- ic2arb_addr, in, XLEN: I-cache address.
- arb2mem_command, out, 2: command driven to memory.
- arb2mem_addr, out, XLEN: address driven to memory.
- arb2mem_data, out, 64: store data driven to memory.
- mem2arb_response, in, TAG_W: nonzero means this cycle's command was accepted with that tag.
- mem2arb_data, in, 64: returning load data.
- mem2arb_tag, in, TAG_W: tag of the returning data; 0 means no return.
- arb2dc_accept, out, 1: D-cache request accepted by memory this cycle.
- arb2dc_valid, out, 1: D-cache load data valid this cycle.
- arb2dc_data, out, 64: D-cache load data.
- arb2ic_accept, out, 1: I-cache request accepted by memory this cycle.
- arb2ic_valid, out, 1: I-cache load data valid this cycle.
- arb2ic_data, out, 64: I-cache load data.

Behaviour:
- Grant (combinational):
  - If D-cache command != BUS_NONE and starve_cnt < STARVE_LIMIT, grant the D-cache.
  - Otherwise, if I-cache command != BUS_NONE, grant the I-cache.
  - Otherwise, grant nobody.
  - Forced I-cache grant when starve_cnt == STARVE_LIMIT and the I-cache is requesting.
- Forwarding: the granted requester's command, addr and data go to arb2mem_* in the same cycle. With no grant, arb2mem_command = BUS_NONE and addr/data = 0. The I-cache path drives data = 0.
- Accept: arb2X_accept = granted to X AND mem2arb_response != 0. It is combinational and the same cycle as the grant. A non-accepted request is the requester's to hold and retry; the arbiter keeps no request queue.
- Owner table: NUM_TAGS entries of {valid, owner (0 = D-cache, 1 = I-cache)}.
  - On an accepted BUS_LOAD, the next edge sets entry[mem2arb_response] to valid with the owner.
  - Accepted BUS_STOREs allocate no entry.
- Return routing:
  - When mem2arb_tag != 0 and entry[mem2arb_tag].valid, pulse the owner's arb2X_valid for exactly that cycle, with arb2X_data = mem2arb_data.
  - The next edge clears the entry.
  - A tag that is 0 or has an invalid entry is dropped; no valid pulse on either side.
- Simultaneous events:
  - A return on tag T and a new allocation of tag T in the same cycle: the return routes to the old owner, and the allocation wins, so the entry ends valid with the new owner.
  - Accept and return for the same cache in one cycle are both signalled.
- Starvation counter (TAG_W+1 bits, saturating at STARVE_LIMIT):
  - Increments on each cycle the I-cache requests and is not accepted.
  - Clears on I-cache accept, or on any cycle with ic2arb_command == BUS_NONE.
- Reset:
  - All table entries become invalid and starve_cnt = 0.
  - All accept/valid outputs are 0, data outputs are 0, and arb2mem_command = BUS_NONE while rst is high.
  - Responses for transactions issued before reset find invalid entries and are dropped.
- arb2X_data outputs are 0 whenever the matching valid is low.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds three 32-bit output ports, each a wrapping counter cleared by rst:
  - stat_dc_grants: counts D-cache accepts.
  - stat_ic_grants: counts I-cache accepts.
  - stat_stall_cycles: counts cycles where any request is present but mem2arb_response == 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- D-cache BUS_LOAD addr 0x100, response 3 → arb2dc_accept = 1 that cycle. Later mem2arb_tag = 3, data 0xDEADBEEF_CAFEF00D → arb2dc_valid one cycle with that data; arb2ic_valid stays 0.
- Both request every cycle with response 5 → the D-cache wins 8 cycles, then the I-cache is accepted on the 9th; starve_cnt returns to 0.
- Request with response 0 → no accept and no table allocation. The same request with response 7 next cycle → accept, entry 7 owned by the requester.
- D-cache BUS_STORE addr 0x200, data 0x1234, response 2, then mem2arb_tag = 2 → no valid pulse (no entry allocated).
- Tag 4 allocated to the I-cache, then in one cycle tag 4 returns while a new D-cache load is accepted with tag 4 → arb2ic_valid this cycle; the next return on tag 4 goes to the D-cache.
- I-cache load accepted on tag 6, rst asserted for one cycle, then mem2arb_tag = 6 → no valid pulse; all outputs 0 / BUS_NONE during rst.
